// File: rtl/reg_bus_pkg.sv
// Shared types and default sizing for the register-bus initiator.
// REG_BUS_MASTER_WRITE_VERIFY_EN adds the VERIFY state used for write readback.
package reg_bus_pkg;

    localparam int DEF_NUM_REGS       = 8;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RESP   = 3'd3
`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
        ,
        ST_VERIFY = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/reg_bus_master_if.sv
// Command, response and register-side signals of the register-bus initiator.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge.
interface reg_bus_master_if
    import reg_bus_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [ADDR_W-1:0]          cmd_addr;
    logic [DATA_W-1:0]          cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic [NUM_REGS-1:0]        reg_wen;
    logic [NUM_REGS-1:0]        reg_ren;
    logic [DATA_W-1:0]          reg_wdata;
    logic [NUM_REGS*DATA_W-1:0] reg_rdata;
    logic [NUM_REGS-1:0]        reg_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, reg_rdata, reg_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_wen, reg_ren, reg_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, reg_rdata, reg_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, reg_wen, reg_ren, reg_wdata
    );

endinterface

// File: rtl/reg_bus_timer.sv
// Read-wait counter; expired_o flags the last permitted read-enable cycle.
module reg_bus_timer
    import reg_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // count_q is the number of enable cycles already completed before this one
    assign expired_o = enable_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: one command at a time, one-hot write strobe or held read enable.
// Define REG_BUS_MASTER_WRITE_VERIFY_EN to read back and compare every write.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    reg_bus_master_if.master bus,
    output state_e           dbg_state_o
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REGS-1:0] wen_q, wen_d;
    logic [NUM_REGS-1:0] ren_q, ren_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                accept;
    logic                waiting;
    logic                timer_expired;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign sel_ready     = bus.reg_ready[addr_q];
    assign sel_rdata     = bus.reg_rdata[int'(addr_q) * DATA_W +: DATA_W];

`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
    assign waiting = (state_q == ST_READ) || (state_q == ST_VERIFY);
`else
    assign waiting = (state_q == ST_READ);
`endif

    reg_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!waiting),
        .enable_i  (waiting),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = '0;
        ren_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    if (int'(bus.cmd_addr) >= NUM_REGS) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.cmd_write) begin
                        state_d = ST_WRITE;
                        wen_d   = ONE << bus.cmd_addr;
                    end else begin
                        state_d = ST_READ;
                        ren_d   = ONE << bus.cmd_addr;
                    end
                end
            end
            ST_WRITE: begin
`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
                state_d = ST_VERIFY;
                ren_d   = ONE << addr_q;
`else
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
`endif
            end
            ST_READ: begin
                // a ready in the final allowed cycle still wins over the timeout
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = sel_rdata;
                end else if (timer_expired) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    ren_d = ren_q;
                end
            end
`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
            ST_VERIFY: begin
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (sel_rdata != wdata_q);
                    rsp_rdata_d = sel_rdata;
                end else if (timer_expired) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    ren_d = ren_q;
                end
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            ren_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.reg_wen   = wen_q;
    assign bus.reg_ren   = ren_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: an 8-register instance with a one-cycle
// responder model, and a 6-register instance for unmapped-address cases.
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg8, dbg6;

    int n_tests = 0;
    int n_fail  = 0;

    // responder model knobs
    logic       never_ready  = 1'b0;
    logic [7:0] corrupt_mask = 8'h00;

    logic [7:0]  regfile [8];
    logic [63:0] rdat_q = '0;
    logic [7:0]  rdy_q  = '0;

    reg_bus_master_if #(.NUM_REGS(8), .DATA_W(8)) bus8 ();
    reg_bus_master_if #(.NUM_REGS(6), .DATA_W(8)) bus6 ();

    reg_bus_master #(.NUM_REGS(8), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus8.master),
        .dbg_state_o (dbg8)
    );

    reg_bus_master #(.NUM_REGS(6), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut6 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus6.master),
        .dbg_state_o (dbg6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bus8.reg_wen[i] === 1'b1) regfile[i] <= bus8.reg_wdata;
            if (bus8.reg_ren[i] === 1'b1 && !never_ready) begin
                rdy_q[i]            <= 1'b1;
                rdat_q[i*8 +: 8]    <= regfile[i] & ~corrupt_mask;
            end else begin
                rdy_q[i]            <= 1'b0;
                rdat_q[i*8 +: 8]    <= 8'h00;
            end
        end
    end

    assign bus8.reg_rdata = rdat_q;
    assign bus8.reg_ready = rdy_q;
    assign bus6.reg_rdata = '0;
    assign bus6.reg_ready = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the caller at the falling edge of cycle T+1.
    task automatic send8(input logic w, input logic [2:0] a, input logic [7:0] d);
        int guard = 0;
        bus8.cmd_valid = 1'b1;
        bus8.cmd_write = w;
        bus8.cmd_addr  = a;
        bus8.cmd_wdata = d;
        while (!bus8.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd8_ready", 32'(bus8.cmd_ready), 1);
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
    endtask

    task automatic send6(input logic w, input logic [2:0] a, input logic [7:0] d);
        int guard = 0;
        bus6.cmd_valid = 1'b1;
        bus6.cmd_write = w;
        bus6.cmd_addr  = a;
        bus6.cmd_wdata = d;
        while (!bus6.cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd6_ready", 32'(bus6.cmd_ready), 1);
        @(negedge clk);
        bus6.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp8();
        int guard = 0;
        while (!bus8.rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rsp8_valid", 32'(bus8.rsp_valid), 1);
    endtask

    task automatic do_write8(input logic [2:0] a, input logic [7:0] d);
        send8(1'b1, a, d);
        wait_rsp8();
        check_eq("wr_err", 32'(bus8.rsp_err), 0);
        @(negedge clk);
    endtask

    task automatic do_read8(input logic [2:0] a, output logic [7:0] rd, output logic er);
        send8(1'b0, a, 8'h00);
        wait_rsp8();
        rd = bus8.rsp_rdata;
        er = bus8.rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         ren_cycles;
        int         lat;

        bus8.cmd_valid = 1'b0; bus8.cmd_write = 1'b0; bus8.cmd_addr = '0;
        bus8.cmd_wdata = '0;   bus8.rsp_ready = 1'b1;
        bus6.cmd_valid = 1'b0; bus6.cmd_write = 1'b0; bus6.cmd_addr = '0;
        bus6.cmd_wdata = '0;   bus6.rsp_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready_low", 32'(bus8.cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_ready_high", 32'(bus8.cmd_ready), 1);
        check_eq("rst_rsp_valid", 32'(bus8.rsp_valid), 0);
        check_eq("rst_rsp_rdata", 32'(bus8.rsp_rdata), 0);
        check_eq("rst_rsp_err", 32'(bus8.rsp_err), 0);
        check_eq("rst_wen", 32'(bus8.reg_wen), 0);
        check_eq("rst_ren", 32'(bus8.reg_ren), 0);
        check_eq("rst_wdata", 32'(bus8.reg_wdata), 0);
        check_eq("rst_state", 32'(dbg8), 32'(ST_IDLE));
        check_eq("rst_cmd_ready6", 32'(bus6.cmd_ready), 1);

        // write addr 3 <= 0xA5
        send8(1'b1, 3'd3, 8'hA5);
        check_eq("wr_wen_t1", 32'(bus8.reg_wen), 32'h08);
        check_eq("wr_wdata_t1", 32'(bus8.reg_wdata), 32'hA5);
        check_eq("wr_rsp_t1", 32'(bus8.rsp_valid), 0);
        @(negedge clk);
        check_eq("wr_wen_t2", 32'(bus8.reg_wen), 0);
`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
        check_eq("wv_ren_t2", 32'(bus8.reg_ren), 32'h08);
        check_eq("wv_rsp_t2", 32'(bus8.rsp_valid), 0);
        @(negedge clk);
        check_eq("wv_ren_t3", 32'(bus8.reg_ren), 32'h08);
        check_eq("wv_rsp_t3", 32'(bus8.rsp_valid), 0);
        @(negedge clk);
        check_eq("wv_ren_t4", 32'(bus8.reg_ren), 0);
        check_eq("wv_rsp_t4", 32'(bus8.rsp_valid), 1);
        check_eq("wv_err_t4", 32'(bus8.rsp_err), 0);
        check_eq("wv_rdata_t4", 32'(bus8.rsp_rdata), 32'hA5);
`else
        check_eq("wr_rsp_t2", 32'(bus8.rsp_valid), 1);
        check_eq("wr_err_t2", 32'(bus8.rsp_err), 0);
        check_eq("wr_rdata_t2", 32'(bus8.rsp_rdata), 0);
`endif
        @(negedge clk);
        check_eq("wr_rsp_done", 32'(bus8.rsp_valid), 0);
        check_eq("wr_idle_ready", 32'(bus8.cmd_ready), 1);

        // read addr 5 from a one-cycle responder holding 0x3C
        do_write8(3'd5, 8'h3C);
        send8(1'b0, 3'd5, 8'h00);
        check_eq("rd_ren_t1", 32'(bus8.reg_ren), 32'h20);
        check_eq("rd_rsp_t1", 32'(bus8.rsp_valid), 0);
        @(negedge clk);
        check_eq("rd_ren_t2", 32'(bus8.reg_ren), 32'h20);
        check_eq("rd_wen_t2", 32'(bus8.reg_wen), 0);
        check_eq("rd_rsp_t2", 32'(bus8.rsp_valid), 0);
        @(negedge clk);
        check_eq("rd_ren_t3", 32'(bus8.reg_ren), 0);
        check_eq("rd_rsp_t3", 32'(bus8.rsp_valid), 1);
        check_eq("rd_rdata_t3", 32'(bus8.rsp_rdata), 32'h3C);
        check_eq("rd_err_t3", 32'(bus8.rsp_err), 0);
        @(negedge clk);
        do_read8(3'd3, rd, er);
        check_eq("rd3_rdata", 32'(rd), 32'hA5);
        check_eq("rd3_err", 32'(er), 0);

        // read timeout on addr 2
        never_ready = 1'b1;
        send8(1'b0, 3'd2, 8'h00);
        ren_cycles = 0;
        lat = 1;
        while (!bus8.rsp_valid && lat < 40) begin
            if (bus8.reg_ren == 8'h04) ren_cycles++;
            @(negedge clk);
            lat++;
        end
        check_eq("to_ren_cycles", 32'(ren_cycles), 15);
        check_eq("to_latency", 32'(lat), 16);
        check_eq("to_ren_low", 32'(bus8.reg_ren), 0);
        check_eq("to_err", 32'(bus8.rsp_err), 1);
        check_eq("to_rdata", 32'(bus8.rsp_rdata), 0);
        @(negedge clk);
        never_ready = 1'b0;

        // unmapped addresses on the 6-register instance
        send6(1'b0, 3'd7, 8'h00);
        check_eq("um_rsp_t1", 32'(bus6.rsp_valid), 1);
        check_eq("um_err_t1", 32'(bus6.rsp_err), 1);
        check_eq("um_rdata_t1", 32'(bus6.rsp_rdata), 0);
        check_eq("um_ren_t1", 32'(bus6.reg_ren), 0);
        @(negedge clk);
        check_eq("um_rsp_done", 32'(bus6.rsp_valid), 0);
        send6(1'b1, 3'd6, 8'h99);
        check_eq("um6_wen_t1", 32'(bus6.reg_wen), 0);
        check_eq("um6_err_t1", 32'(bus6.rsp_err), 1);
        check_eq("um6_rsp_t1", 32'(bus6.rsp_valid), 1);
        @(negedge clk);

        // backpressure with a competing command held on the port
        do_write8(3'd1, 8'h11);
        bus8.rsp_ready = 1'b0;
        send8(1'b0, 3'd1, 8'h00);
        wait_rsp8();
        bus8.cmd_valid = 1'b1;
        bus8.cmd_write = 1'b1;
        bus8.cmd_addr  = 3'd6;
        bus8.cmd_wdata = 8'h77;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_rsp_valid", 32'(bus8.rsp_valid), 1);
            check_eq("bp_rdata", 32'(bus8.rsp_rdata), 32'h11);
            check_eq("bp_err", 32'(bus8.rsp_err), 0);
            check_eq("bp_cmd_ready", 32'(bus8.cmd_ready), 0);
            check_eq("bp_wen", 32'(bus8.reg_wen), 0);
            if (k == 4) bus8.rsp_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("bp_rsp_done", 32'(bus8.rsp_valid), 0);
        check_eq("bp_cmd_ready_after", 32'(bus8.cmd_ready), 1);
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        check_eq("bp_wen_late", 32'(bus8.reg_wen), 32'h40);
        check_eq("bp_wdata_late", 32'(bus8.reg_wdata), 32'h77);
        wait_rsp8();
        check_eq("bp_late_err", 32'(bus8.rsp_err), 0);
        @(negedge clk);

        // reset in the middle of a read
        do_write8(3'd4, 8'h44);
        send8(1'b0, 3'd4, 8'h00);
        check_eq("mr_ren_t1", 32'(bus8.reg_ren), 32'h10);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mr_ren_dropped", 32'(bus8.reg_ren), 0);
        check_eq("mr_rsp_none", 32'(bus8.rsp_valid), 0);
        check_eq("mr_cmd_ready_rst", 32'(bus8.cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr_rsp_none2", 32'(bus8.rsp_valid), 0);
        check_eq("mr_cmd_ready", 32'(bus8.cmd_ready), 1);
        do_read8(3'd4, rd, er);
        check_eq("mr_next_rdata", 32'(rd), 32'h44);
        check_eq("mr_next_err", 32'(er), 0);

`ifdef REG_BUS_MASTER_WRITE_VERIFY_EN
        // readback corrupted by the responder: 0x5A reads as 0x58
        corrupt_mask = 8'h02;
        send8(1'b1, 3'd0, 8'h5A);
        wait_rsp8();
        check_eq("wv_bad_err", 32'(bus8.rsp_err), 1);
        check_eq("wv_bad_rdata", 32'(bus8.rsp_rdata), 32'h58);
        @(negedge clk);
        corrupt_mask = 8'h00;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Initiator side of the per-register wen/ren/wdata/rdata/ready access protocol used by the FFT control registers. It accepts one command at a time over a valid/ready port and converts it into a one-hot write strobe or a held read enable toward NUM_REGS register responders. It returns a response with read data and an error flag; the error flag covers unmapped addresses and read timeouts. It sits between the host-side command source (e.g. a SPI/scan front end) and the register file.

## Interface
- NUM_REGS, 8: number of register responders; must be >= 2.
- DATA_W, 8: register data width.
- TIMEOUT_CYCLES, 15: maximum read-enable cycles to wait for ready; must be >= 2.
- ADDR_W, $clog2(NUM_REGS): derived; not overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master idle and able to accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register index.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  unmapped address, or read timeout/mismatch.
- reg_wen  out  NUM_REGS  one-hot write strobe.
- reg_ren  out  NUM_REGS  one-hot read enable.
- reg_wdata  out  DATA_W  shared write data.
- reg_rdata  in  NUM_REGS*DATA_W  responder data; slice i belongs to register i.
- reg_ready  in  NUM_REGS  responder read-ready; bit i belongs to register i.

## Operation
- FSM states are IDLE, WRITE, READ and RESP. With the configuration macro defined, a VERIFY state is added.
- **IDLE:** cmd_ready=1. When cmd_valid && cmd_ready, latch write/addr/wdata.
  - addr >= NUM_REGS: go to RESP with err=1 and rdata=0. No strobe is issued.
  - write: go to WRITE.
  - read: go to READ.
- **WRITE:** reg_wen[addr]=1 and reg_wdata=latched data for exactly one cycle. Then go to RESP with err=0 and rdata=0.
- **READ:** reg_ren[addr] is held at 1 and a wait counter increments each cycle.
  - Only reg_ready[addr] is examined; all other ready bits are ignored.
  - When reg_ready[addr] is sampled at 1, capture that register's rdata slice, drop ren and go to RESP with err=0.
  - When the counter reaches TIMEOUT_CYCLES without ready, drop ren and go to RESP with err=1 and rdata=0.
- **RESP:** rsp_valid is held at 1 with stable rdata/err until rsp_ready is sampled at 1, then return to IDLE.
  - Because RESP lasts at least one cycle, reg_ren is low for at least one cycle between consecutive reads. Responders clear their rdata/ready during that cycle.
- Every strobe vector is zero or one-hot.
  - reg_wen and reg_ren are never high in the same cycle.
  - Both are zero in IDLE and RESP.
- reg_wdata holds the last latched write data. Its value is don't-care when reg_wen is 0.

## Timing
- All outputs are registered except cmd_ready, which is decoded from state==IDLE.
- Reset values: cmd_ready=0 during rst, 1 in the first cycle after rst. rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_wen=0, reg_ren=0, reg_wdata=0, counter=0, state=IDLE.
- Let T be the cycle in which the command is accepted.
  - **Write:** reg_wen is high in T+1 only; rsp_valid rises in T+2.
  - **Read with a one-cycle responder:** reg_ren is high in T+1 and T+2; the responder's ready is high in T+2; ren is low and rsp_valid is high in T+3.
  - **Read timeout:** reg_ren is high for exactly TIMEOUT_CYCLES cycles; rsp_valid follows in the next cycle.
  - **Unmapped address:** rsp_valid is high in T+1.
- Back-to-back throughput: a new command can be accepted one cycle after the response handshake.
- cmd_valid while busy is not accepted, and the command inputs are not sampled.
- rst asserted mid-transaction: strobes drop the following cycle, the in-flight command is discarded, and no response is issued.

## Configuration
- REG_BUS_MASTER_WRITE_VERIFY_EN defined: after WRITE, the FSM enters VERIFY.
  - VERIFY performs a READ-identical sequence on the same address, including the timeout.
  - rsp_rdata = readback value.
  - rsp_err = timeout OR (readback != written data).
  - A write then has 4-cycle latency to rsp_valid with a one-cycle responder.
- Macro undefined: the VERIFY state and comparator are absent, and writes respond as described under Operation.

## Structure
- Package reg_bus_pkg holds the FSM state enum and the default parameter constants.
- Sub-module reg_bus_timer holds the wait counter. Its ports are clear, enable and an expired output at TIMEOUT_CYCLES. It is shared by READ and VERIFY.

## Test plan
- **Write:** write addr 3, data 0xA5 -> reg_wen=0b00001000 in T+1 only, reg_wdata=0xA5; rsp_valid in T+2 with err=0, rdata=0.
- **Read:** read addr 5 from a responder holding 0x3C -> reg_ren[5] high for 2 cycles; rsp_rdata=0x3C, err=0 at T+3.
- **Read timeout:** read addr 2 with reg_ready tied 0 -> ren held exactly 15 cycles; rsp_err=1, rdata=0.
- **Unmapped address:** NUM_REGS=6, read addr 7 -> no strobe; rsp_valid at T+1 with err=1.
- **Backpressure and busy:** hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout. A cmd_valid presented meanwhile is accepted only after the handshake.
- **Reset mid-read:** assert rst in T+1 of a read -> reg_ren=0 and rsp_valid=0 the next cycle; the next command completes normally. With the macro defined, a write of 0x5A whose readback returns 0x58 -> err=1, rdata=0x58.
